// File: rtl/seq_gen_pkg.sv
// Shared state encoding, display constants and hex-to-segment lookup for the
// serial pattern transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_ALL  = 8'hFF;

  // Active-high segments, bit0=a .. bit6=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sequence_generator_seg7.sv
// Combinational hex digit to 7-segment decoder; decimal point passes straight through.
module seg7_hex_decoder
  import seq_gen_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {dp_i, hex_to_seg(hex_i)};

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a captured pattern out MSB first, each bit
// held bit_div+1 cycles, repeated reps times, with a registered 7-seg status.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int DIV_W = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [DIV_W-1:0] bit_div,
  input  logic [REP_W-1:0] reps,
  output logic             ser_out,
  output logic             ser_strobe,
  output logic             busy,
  output logic             done,
  output logic [7:0]       seg
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_rld_q;
  logic [REP_W-1:0] rep_q;
  logic [IDX_W-1:0] idx_q;
  logic             ser_q;
  logic             strobe_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       seg_q;

  logic [REP_W-1:0] reps_eff;
  logic             bit_end;
  logic             last_bit;
  logic             last_rep;
  logic             ser_d;
  logic [REP_W-1:0] rep_d;
  logic [7:0]       seg_d;

  assign reps_eff = (reps == '0) ? REP_W'(1) : reps;
  assign bit_end  = (div_q == '0);
  assign last_bit = (idx_q == '0);
  assign last_rep = (rep_q <= REP_W'(1));

  // Next serial bit and next remaining-reps value, so seg can be registered
  // in the same cycle as the bit it annotates.
  always_comb begin
    ser_d = 1'b0;
    rep_d = rep_q;
    case (state_q)
      ST_IDLE: begin
        ser_d = pattern[PAT_W-1];
        rep_d = reps_eff;
      end
      ST_SHIFT: begin
        if (!bit_end) begin
          ser_d = pat_q[idx_q];
        end else if (!last_bit) begin
          ser_d = pat_q[idx_q - IDX_W'(1)];
        end else begin
          ser_d = pat_q[PAT_W-1];
          rep_d = rep_q - REP_W'(1);
        end
      end
      default: begin
        ser_d = 1'b0;
        rep_d = rep_q;
      end
    endcase
  end

  seg7_hex_decoder u_seg7 (
    .hex_i (4'(rep_d)),
    .dp_i  (ser_d),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      div_q     <= '0;
      div_rld_q <= '0;
      rep_q     <= '0;
      idx_q     <= '0;
      ser_q     <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_q     <= SEG_DASH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ser_q    <= 1'b0;
          strobe_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          seg_q    <= SEG_DASH;
          if (start) begin
            pat_q     <= pattern;
            div_q     <= bit_div;
            div_rld_q <= bit_div;
            rep_q     <= reps_eff;
            idx_q     <= IDX_TOP;
            ser_q     <= ser_d;
            strobe_q  <= 1'b1;
            busy_q    <= 1'b1;
            seg_q     <= seg_d;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!bit_end) begin
            div_q    <= div_q - DIV_W'(1);
            ser_q    <= ser_d;
            strobe_q <= 1'b0;
            seg_q    <= seg_d;
          end else if (last_bit && last_rep) begin
            ser_q    <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            seg_q    <= SEG_ALL;
            state_q  <= ST_DONE;
          end else begin
            // Repetitions run back-to-back: wrap idx without a gap bit.
            div_q    <= div_rld_q;
            ser_q    <= ser_d;
            strobe_q <= 1'b1;
            seg_q    <= seg_d;
            if (last_bit) begin
              idx_q <= IDX_TOP;
              rep_q <= rep_q - REP_W'(1);
            end else begin
              idx_q <= idx_q - IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          ser_q    <= 1'b0;
          strobe_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          seg_q    <= SEG_DASH;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ser_out    = ser_q;
  assign ser_strobe = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: table-driven reset/basic vectors plus
// hand-written multi-cycle sequences for repetition, reset abort and loopback.
module tb_sequence_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] pattern;
  logic [7:0] bit_div;
  logic [3:0] reps;
  logic       ser_out;
  logic       ser_strobe;
  logic       busy;
  logic       done;
  logic [7:0] seg;

  int n_vec = 0;
  int n_bad = 0;

  sequence_generator #(.PAT_W(3), .DIV_W(8), .REP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .bit_div    (bit_div),
    .reps       (reps),
    .ser_out    (ser_out),
    .ser_strobe (ser_strobe),
    .busy       (busy),
    .done       (done),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [2:0] pat;
    logic [7:0] div;
    logic [3:0] reps;
    logic       e_ser;
    logic       e_stb;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_seg;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic s, input logic st, input logic b,
                         input logic d, input logic [7:0] sg);
    chk({tag, ".ser_out"}, 32'(ser_out), 32'(s));
    chk({tag, ".strobe"}, 32'(ser_strobe), 32'(st));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".seg"}, 32'(seg), 32'(sg));
  endtask

  initial begin
    logic [17:0] e3;
    logic [6:0]  dig;
    int          busy_cnt;
    int          done_cnt;
    int          det_cnt;
    int          nbits;
    logic [5:0]  got4;
    logic [2:0]  hist;

    rst = 1'b1; start = 1'b0; pattern = '0; bit_div = '0; reps = '0;

    //           rst  st  pat     div reps  ser stb busy done seg
    tbl[0] = '{1'b1, 1'b0, 3'b000, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40};
    tbl[1] = '{1'b1, 1'b0, 3'b000, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40};
    tbl[2] = '{1'b0, 1'b1, 3'b100, 8'd0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h86};
    tbl[3] = '{1'b0, 1'b0, 3'b100, 8'd0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h06};
    tbl[4] = '{1'b0, 1'b0, 3'b100, 8'd0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h06};
    tbl[5] = '{1'b0, 1'b0, 3'b100, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
    tbl[6] = '{1'b0, 1'b1, 3'b111, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40};
    tbl[7] = '{1'b0, 1'b0, 3'b000, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40};

    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; pattern = tbl[i].pat;
      bit_div = tbl[i].div; reps = tbl[i].reps;
      step();
      chk_all($sformatf("tbl%0d", i), tbl[i].e_ser, tbl[i].e_stb, tbl[i].e_busy,
              tbl[i].e_done, tbl[i].e_seg);
    end

    // Pattern 101, 3 cycles per bit, 2 reps; inputs scrambled after capture.
    e3 = 18'b111000111111000111;
    pattern = 3'b101; bit_div = 8'd2; reps = 4'd2; start = 1'b1;
    step();
    start = 1'b0; pattern = 3'b010; bit_div = 8'd0; reps = 4'd7;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) step();
      dig = (i < 9) ? 7'h5B : 7'h06;
      chk($sformatf("t3.ser[%0d]", i), 32'(ser_out), 32'(e3[17-i]));
      chk($sformatf("t3.stb[%0d]", i), 32'(ser_strobe), 32'((i % 3) == 0));
      chk($sformatf("t3.busy[%0d]", i), 32'(busy), 32'd1);
      chk($sformatf("t3.done[%0d]", i), 32'(done), 32'd0);
      chk($sformatf("t3.seg[%0d]", i), 32'(seg), 32'({e3[17-i], dig}));
    end
    step();
    chk_all("t3.end", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    step();
    chk_all("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);

    // reps=0 means one repetition; a start pulse while busy is dropped.
    pattern = 3'b110; bit_div = 8'd1; reps = 4'd0; start = 1'b1;
    busy_cnt = 0; done_cnt = 0; got4 = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      start = (i == 2);
      if (i == 2) begin pattern = 3'b011; reps = 4'd3; end
      if (busy) begin
        if (busy_cnt < 6) got4 = {got4[4:0], ser_out};
        busy_cnt++;
      end
      if (done) done_cnt++;
    end
    start = 1'b0;
    chk("t4.busy_cycles", 32'(busy_cnt), 32'd6);
    chk("t4.done_count", 32'(done_cnt), 32'd1);
    chk("t4.bits", 32'(got4), 32'b111100);

    // Reset in the fifth cycle of a transmission aborts without a done.
    pattern = 3'b101; bit_div = 8'd2; reps = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t5.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("t5.rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk("t5.no_done", 32'(done_cnt), 32'd0);
    chk("t5.no_busy", 32'(busy_cnt), 32'd0);
    pattern = 3'b100; bit_div = 8'd0; reps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("t5.re0", 1'b1, 1'b1, 1'b1, 1'b0, 8'h86);
    step();
    chk_all("t5.re1", 1'b0, 1'b1, 1'b1, 1'b0, 8'h06);
    step();
    chk_all("t5.re2", 1'b0, 1'b1, 1'b1, 1'b0, 8'h06);
    step();
    chk_all("t5.re3", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    step();

    // Loopback into a 100-pattern detector sampled on each bit strobe.
    pattern = 3'b100; bit_div = 8'd0; reps = 4'd3; start = 1'b1;
    det_cnt = 0; nbits = 0; hist = '0; done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      start = 1'b0;
      if (ser_strobe) begin
        hist = {hist[1:0], ser_out};
        nbits++;
        if (nbits >= 3 && hist == 3'b100) det_cnt++;
      end
      if (done) done_cnt++;
    end
    chk("t6.detections", 32'(det_cnt), 32'd3);
    chk("t6.bits", 32'(nbits), 32'd9);
    chk("t6.done", 32'(done_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
